// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - VGA raster timing signal bundle between timing generator and pixel pipeline
interface vga_timing_gen_if;
  logic       pixel_clk;
  logic       pixel_ce;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic       sync_n;
  logic       frame_start;
  logic       vblank_start;

  modport master (
    output pixel_clk, pixel_ce, DrawX, DrawY, hs, vs, blank_n, sync_n,
           frame_start, vblank_start
  );

  modport slave (
    input pixel_clk, pixel_ce, DrawX, DrawY, hs, vs, blank_n, sync_n,
          frame_start, vblank_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster counters, syncs, blanking and frame strobes
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic            Clk,
  input  logic            Reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_W  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic       phase;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs_q;
  logic       vs_q;
  logic       blank_q;
  logic       fs_q;
  logic       vb_q;

  logic [9:0] hc_nxt;
  logic [9:0] vc_nxt;
  logic       hs_nxt;
  logic       vs_nxt;
  logic       blank_nxt;
  logic       fs_nxt;
  logic       vb_nxt;

  // Divide Clk by two; the flop doubles as the DAC pixel clock and the pixel step enable
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end

  // Next raster position and its decode, so registered outputs line up with DrawX/DrawY
  always_comb begin
    hc_nxt = hc + 10'd1;
    vc_nxt = vc;
    if (hc == H_LAST) begin
      hc_nxt = 10'd0;
      if (vc == V_LAST) begin
        vc_nxt = 10'd0;
      end else begin
        vc_nxt = vc + 10'd1;
      end
    end
    hs_nxt    = !((hc_nxt >= HS_START) && (hc_nxt < HS_END));
    vs_nxt    = !((vc_nxt >= VS_START) && (vc_nxt < VS_END));
    blank_nxt = (hc_nxt < H_VIS_W) && (vc_nxt < V_VIS_W);
    fs_nxt    = (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
    vb_nxt    = (hc_nxt == 10'd0) && (vc_nxt == V_VIS_W);
  end

  // Counters and decoded syncs move only on pixel steps and hold otherwise
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc      <= 10'd0;
      vc      <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else if (phase) begin
      hc      <= hc_nxt;
      vc      <= vc_nxt;
      hs_q    <= hs_nxt;
      vs_q    <= vs_nxt;
      blank_q <= blank_nxt;
    end
  end

  // Strobes fire on the step into (0,0) / (0,V_VISIBLE) and clear on the following Clk
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_q <= 1'b0;
      vb_q <= 1'b0;
    end else if (phase) begin
      fs_q <= fs_nxt;
      vb_q <= vb_nxt;
    end else begin
      fs_q <= 1'b0;
      vb_q <= 1'b0;
    end
  end

  assign vga.pixel_clk    = phase;
  assign vga.pixel_ce     = phase;
  assign vga.DrawX        = hc;
  assign vga.DrawY        = vc;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.blank_n      = blank_q;
  assign vga.sync_n       = 1'b0;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen, full-size and shrunk raster instances
module tb_vga_timing_gen;

  localparam int F_HT = 800;
  localparam int F_VT = 525;
  localparam int F_HV = 640;
  localparam int F_VV = 480;
  localparam int F_HS0 = 656;
  localparam int F_HS1 = 752;
  localparam int F_VS0 = 490;
  localparam int F_VS1 = 492;

  localparam int S_HT = 32;
  localparam int S_VT = 19;
  localparam int S_HV = 16;
  localparam int S_VV = 12;
  localparam int S_HS0 = 20;
  localparam int S_HS1 = 28;
  localparam int S_VS0 = 14;
  localparam int S_VS1 = 16;
  localparam int S_FRAME = 2 * S_HT * S_VT;

  logic Clk = 1'b0;
  logic rst_full_n = 1'b0;
  logic rst_small_n = 1'b0;

  always #10 Clk = ~Clk;

  vga_timing_gen_if if_full();
  vga_timing_gen_if if_small();

  vga_timing_gen dut_full (
    .Clk     (Clk),
    .Reset_n (rst_full_n),
    .vga     (if_full)
  );

  vga_timing_gen #(
    .H_VISIBLE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_VISIBLE (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut_small (
    .Clk     (Clk),
    .Reset_n (rst_small_n),
    .vga     (if_small)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs;
    logic vs;
    logic bl;
    logic ce;
    logic pc;
    logic sn;
    logic fs;
    logic vb;
  } smp_t;

  smp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  int   mx, my;
  logic mph, mhs, mvs, mbl, mfs, mvb;

  smp_t rst_val;

  initial begin
    rst_val = '0;
    rst_val.hs = 1'b1;
    rst_val.vs = 1'b1;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic smp_t sample(input bit sm);
    smp_t s;
    if (sm) begin
      s = {if_small.DrawX, if_small.DrawY, if_small.hs, if_small.vs, if_small.blank_n,
           if_small.pixel_ce, if_small.pixel_clk, if_small.sync_n,
           if_small.frame_start, if_small.vblank_start};
    end else begin
      s = {if_full.DrawX, if_full.DrawY, if_full.hs, if_full.vs, if_full.blank_n,
           if_full.pixel_ce, if_full.pixel_clk, if_full.sync_n,
           if_full.frame_start, if_full.vblank_start};
    end
    return s;
  endfunction

  task automatic model_reset;
    mx = 0; my = 0; mph = 1'b0;
    mhs = 1'b1; mvs = 1'b1; mbl = 1'b0; mfs = 1'b0; mvb = 1'b0;
  endtask

  // Reference raster: advances on the Clk edge that sees the enable high, pushes the expected sample
  task automatic model_step(input bit sm);
    int ht, vt, hv, vv, hs0, hs1, vs0, vs1;
    smp_t e;
    ht  = sm ? S_HT  : F_HT;   vt  = sm ? S_VT  : F_VT;
    hv  = sm ? S_HV  : F_HV;   vv  = sm ? S_VV  : F_VV;
    hs0 = sm ? S_HS0 : F_HS0;  hs1 = sm ? S_HS1 : F_HS1;
    vs0 = sm ? S_VS0 : F_VS0;  vs1 = sm ? S_VS1 : F_VS1;
    if (mph) begin
      if (mx == ht - 1) begin
        mx = 0;
        my = (my == vt - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      mhs = !(mx >= hs0 && mx < hs1);
      mvs = !(my >= vs0 && my < vs1);
      mbl = (mx < hv) && (my < vv);
      mfs = (mx == 0) && (my == 0);
      mvb = (mx == 0) && (my == vv);
    end else begin
      mfs = 1'b0;
      mvb = 1'b0;
    end
    mph = !mph;
    e = {10'(mx), 10'(my), mhs, mvs, mbl, mph, mph, 1'b0, mfs, mvb};
    sb_q.push_back(e);
  endtask

  task automatic sb_step(input bit sm, output smp_t e, output smp_t a);
    model_step(sm);
    tick();
    e = sb_q.pop_front();
    a = sample(sm);
  endtask

  task automatic test_reset;
    smp_t a;
    repeat (3) tick();
    for (int sm = 0; sm < 2; sm++) begin
      a = sample(sm[0]);
      checks++;
      if (a !== rst_val) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h exp %h", sm, a, rst_val);
      end
    end
  endtask

  task automatic test_first_pixels;
    smp_t e, a;
    int nce;
    bit bl_seen;
    nce = 0;
    bl_seen = 0;
    rst_full_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      sb_step(1'b0, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL first_pixels cyc %0d got %h exp %h", i, a, e);
      end
      if (a.ce) nce++;
      if (a.bl && !bl_seen) begin
        bl_seen = 1;
        checks++;
        if (a.x !== 10'd1) begin
          errors++;
          $display("FAIL first_blank_x got %0d exp 1", a.x);
        end
      end
    end
    checks++;
    if (nce != 4 || a.x !== 10'd4 || !bl_seen) begin
      errors++;
      $display("FAIL first_summary ce %0d exp 4 x %0d exp 4 blank_seen %0d exp 1", nce, a.x, bl_seen);
    end
  endtask

  task automatic test_line;
    smp_t e, a, p;
    bit hs_fall, hs_rise, bl_fall, wrap;
    hs_fall = 0; hs_rise = 0; bl_fall = 0; wrap = 0;
    p = sample(1'b0);
    for (int i = 0; i < 2 * F_HT; i++) begin
      sb_step(1'b0, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL line cyc %0d got %h exp %h", i, a, e);
      end
      if (p.hs && !a.hs) begin
        hs_fall = 1; checks++;
        if (a.x !== 10'd656) begin errors++; $display("FAIL hs_fall_x got %0d exp 656", a.x); end
      end
      if (!p.hs && a.hs) begin
        hs_rise = 1; checks++;
        if (a.x !== 10'd752) begin errors++; $display("FAIL hs_rise_x got %0d exp 752", a.x); end
      end
      if (p.bl && !a.bl) begin
        bl_fall = 1; checks++;
        if (a.x !== 10'd640) begin errors++; $display("FAIL blank_fall_x got %0d exp 640", a.x); end
      end
      if (p.x == 10'd799 && a.x == 10'd0) begin
        wrap = 1; checks++;
        if (a.y !== 10'd1) begin errors++; $display("FAIL line_wrap_y got %0d exp 1", a.y); end
      end
      p = a;
    end
    checks++;
    if (!(hs_fall && hs_rise && bl_fall && wrap) || a.x !== 10'd4 || a.y !== 10'd1) begin
      errors++;
      $display("FAIL line_len x %0d y %0d exp 4 1 edges %0d%0d%0d%0d exp 1111",
               a.x, a.y, hs_fall, hs_rise, bl_fall, wrap);
    end
  endtask

  task automatic test_small_release;
    smp_t e, a;
    rst_small_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      sb_step(1'b1, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL small_release cyc %0d got %h exp %h", i, a, e);
      end
    end
  endtask

  task automatic test_frame;
    smp_t e, a, p;
    int vs_low;
    bit wrap;
    vs_low = 0;
    wrap = 0;
    p = sample(1'b1);
    for (int i = 0; i < S_FRAME; i++) begin
      sb_step(1'b1, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL frame cyc %0d got %h exp %h", i, a, e);
      end
      if (!a.vs) vs_low++;
      if (a.y >= 10'd12 && a.bl) begin
        checks++; errors++;
        $display("FAIL vblank_blank y %0d got blank_n 1 exp 0", a.y);
      end
      if (p.y == 10'd18 && a.y == 10'd0) wrap = 1;
      p = a;
    end
    checks++;
    if (vs_low != 4 * S_HT || !wrap) begin
      errors++;
      $display("FAIL frame_vs vs_low %0d exp %0d wrap %0d exp 1", vs_low, 4 * S_HT, wrap);
    end
  endtask

  task automatic test_strobes;
    smp_t e, a, p;
    int nfs, nvb, last_fs, last_vb;
    nfs = 0; nvb = 0; last_fs = -1; last_vb = -1;
    p = sample(1'b1);
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      sb_step(1'b1, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL strobes cyc %0d got %h exp %h", i, a, e);
      end
      if ((a.fs && p.fs) || (a.vb && p.vb)) begin
        checks++; errors++;
        $display("FAIL strobe_width cyc %0d got 2 cycles exp 1", i);
      end
      if (a.fs) begin
        nfs++; checks++;
        if (a.x !== 10'd0 || a.y !== 10'd0 || (last_fs >= 0 && i - last_fs != S_FRAME)) begin
          errors++;
          $display("FAIL frame_start_pos x %0d y %0d gap %0d exp 0 0 %0d", a.x, a.y, i - last_fs, S_FRAME);
        end
        last_fs = i;
      end
      if (a.vb) begin
        nvb++; checks++;
        if (a.x !== 10'd0 || a.y !== 10'd12 || (last_vb >= 0 && i - last_vb != S_FRAME)) begin
          errors++;
          $display("FAIL vblank_start_pos x %0d y %0d gap %0d exp 0 12 %0d", a.x, a.y, i - last_vb, S_FRAME);
        end
        last_vb = i;
      end
      p = a;
    end
    checks++;
    if (nfs != 3 || nvb != 3) begin
      errors++;
      $display("FAIL strobe_count frame_start %0d vblank_start %0d exp 3 3", nfs, nvb);
    end
  endtask

  task automatic test_reset_mid;
    smp_t e, a;
    bit found;
    int nce;
    found = 0;
    for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
      sb_step(1'b1, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL pre_reset cyc %0d got %h exp %h", i, a, e);
      end
      if (a.x == 10'd22 && a.y == 10'd8) found = 1;
    end
    checks++;
    if (!found || a.hs !== 1'b0) begin
      errors++;
      $display("FAIL mid_point found %0d hs %0d exp 1 0", found, a.hs);
    end
    #3;
    rst_small_n = 1'b0;
    #1;
    a = sample(1'b1);
    checks++;
    if (a !== rst_val) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", a, rst_val);
    end
    repeat (2) tick();
    rst_small_n = 1'b1;
    model_reset();
    nce = 0;
    for (int i = 1; i <= 8; i++) begin
      sb_step(1'b1, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL post_reset cyc %0d got %h exp %h", i, a, e);
      end
      if (a.ce) nce++;
    end
    checks++;
    if (nce != 4 || a.x !== 10'd4 || a.y !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_summary ce %0d x %0d y %0d exp 4 4 0", nce, a.x, a.y);
    end
  endtask

  task automatic test_model_2frames;
    smp_t e, a;
    for (int i = 0; i < 2 * S_FRAME; i++) begin
      sb_step(1'b1, e, a);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model cyc %0d got %h exp %h", i, a, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_line();
    test_small_release();
    test_frame();
    test_strobes();
    test_reset_mid();
    test_model_2frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
